// File: rtl/wordle_pkg.sv
// Shared definitions for the Wordle game engine: tile colour codes,
// letter-code limits and the game FSM state encoding.
package wordle_pkg;

    localparam int LETTER_W_DEFAULT = 5;
    localparam int MAX_LETTER_CODE  = 25;

    localparam logic [1:0] COL_EMPTY  = 2'b00;
    localparam logic [1:0] COL_GREY   = 2'b01;
    localparam logic [1:0] COL_YELLOW = 2'b10;
    localparam logic [1:0] COL_GREEN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Codes 0..25 are A..Z; anything above is not a letter.
    function automatic logic letter_is_valid(input int code);
        return code <= MAX_LETTER_CODE;
    endfunction

endpackage

// File: rtl/wordle_scorer.sv
// Scores one guess against the secret. A GREEN pass (one position per
// cycle) marks exact matches, then a YELLOW pass walks every (i, j) pair
// with i outer and j inner, consuming unused secret letters so duplicate
// letters are coloured correctly. The iteration count is fixed so the
// latency never depends on the words.
module wordle_scorer
    import wordle_pkg::*;
#(
    parameter int WORD_LEN = 5,
    parameter int LETTER_W = LETTER_W_DEFAULT
) (
    input  logic                         board_clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic                         abort,
    input  logic [WORD_LEN*LETTER_W-1:0] guess,
    input  logic [WORD_LEN*LETTER_W-1:0] secret,
    output logic [2*WORD_LEN-1:0]        colours,
    output logic                         green_last,
    output logic                         done
);
    localparam int            IW       = $clog2(WORD_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_LEN - 1);

    typedef enum logic [1:0] {PH_IDLE, PH_GREEN, PH_YELLOW} phase_t;

    phase_t              phase_q, phase_d;
    logic [IW-1:0]       i_q, i_d;
    logic [IW-1:0]       j_q, j_d;
    logic [WORD_LEN-1:0] used_q, used_d;
    logic [1:0]          col_q [WORD_LEN];
    logic [1:0]          col_d [WORD_LEN];
    logic [LETTER_W-1:0] guess_l  [WORD_LEN];
    logic [LETTER_W-1:0] secret_l [WORD_LEN];

    for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_lanes
        assign guess_l[gi]          = guess[gi*LETTER_W +: LETTER_W];
        assign secret_l[gi]         = secret[gi*LETTER_W +: LETTER_W];
        assign colours[2*gi +: 2]   = col_q[gi];
    end

    // The top uses these to step its own GREEN -> YELLOW -> UPDATE states.
    assign green_last = (phase_q == PH_GREEN) && (i_q == LAST_IDX);
    assign done       = (phase_q == PH_YELLOW) && (i_q == LAST_IDX) && (j_q == LAST_IDX);

    // Next-state for the two scoring passes and the used[] bookkeeping.
    always_comb begin
        phase_d = phase_q;
        i_d     = i_q;
        j_d     = j_q;
        used_d  = used_q;
        col_d   = col_q;
        if (abort) begin
            phase_d = PH_IDLE;
        end else if (go) begin
            phase_d = PH_GREEN;
            i_d     = '0;
            j_d     = '0;
            used_d  = '0;
            for (int k = 0; k < WORD_LEN; k++) col_d[k] = COL_EMPTY;
        end else begin
            case (phase_q)
                PH_GREEN: begin
                    if (guess_l[i_q] == secret_l[i_q]) begin
                        col_d[i_q]  = COL_GREEN;
                        used_d[i_q] = 1'b1;
                    end
                    if (i_q == LAST_IDX) begin
                        phase_d = PH_YELLOW;
                        i_d     = '0;
                        j_d     = '0;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                PH_YELLOW: begin
                    // Only still-unscored positions look for a spare secret letter.
                    if (col_q[i_q] == COL_EMPTY) begin
                        if (!used_q[j_q] && (secret_l[j_q] == guess_l[i_q])) begin
                            col_d[i_q]  = COL_YELLOW;
                            used_d[j_q] = 1'b1;
                        end else if (j_q == LAST_IDX) begin
                            col_d[i_q] = COL_GREY;
                        end
                    end
                    if (j_q == LAST_IDX) begin
                        j_d = '0;
                        if (i_q == LAST_IDX) phase_d = PH_IDLE;
                        else                 i_d     = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scorer state registers.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            used_q  <= '0;
            for (int k = 0; k < WORD_LEN; k++) col_q[k] <= COL_EMPTY;
        end else begin
            phase_q <= phase_d;
            i_q     <= i_d;
            j_q     <= j_d;
            used_q  <= used_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: rtl/wordle_game_core.sv
// Wordle game engine: collects typed letters into the current row, hands a
// full row to the scorer, commits colours to the board and tracks the guess
// count and win/lose. The tile read port is combinational so the renderer
// never waits on the game FSM.
module wordle_game_core
    import wordle_pkg::*;
#(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6,
    parameter int LETTER_W    = LETTER_W_DEFAULT
) (
    input  logic                               board_clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [WORD_LEN*LETTER_W-1:0]       secret_word,
    input  logic                               letter_valid,
    input  logic [LETTER_W-1:0]                letter,
    input  logic                               backspace,
    input  logic                               submit,
    input  logic [$clog2(MAX_GUESSES)-1:0]     rd_row,
    input  logic [$clog2(WORD_LEN)-1:0]        rd_col,
    output logic [LETTER_W-1:0]                rd_letter,
    output logic [1:0]                         rd_colour,
    output logic                               busy,
    output logic                               score_done,
    output logic [$clog2(MAX_GUESSES+1)-1:0]   guess_count,
    output logic                               win,
    output logic                               lose
);
    localparam int GW   = $clog2(MAX_GUESSES + 1);
    localparam int RIW  = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
    localparam int CIW  = $clog2(WORD_LEN);
    localparam int CURW = $clog2(WORD_LEN + 1);

    state_t                        state_q, state_d;
    logic [CURW-1:0]               cursor_q, cursor_d;
    logic [GW-1:0]                 guess_count_q, guess_count_d;
    logic [WORD_LEN*LETTER_W-1:0]  secret_q, secret_d;
    logic [LETTER_W-1:0]           letters_q [MAX_GUESSES][WORD_LEN];
    logic [LETTER_W-1:0]           letters_d [MAX_GUESSES][WORD_LEN];
    logic [1:0]                    colours_q [MAX_GUESSES][WORD_LEN];
    logic [1:0]                    colours_d [MAX_GUESSES][WORD_LEN];
    logic                          win_q, win_d, lose_q, lose_d;
    logic                          busy_q, busy_d, score_done_q, score_done_d;

    logic [RIW-1:0]                row_idx;
    logic [WORD_LEN*LETTER_W-1:0]  cur_guess;
    logic [2*WORD_LEN-1:0]         score_cols;
    logic [WORD_LEN-1:0]           green_vec;
    logic                          all_green;
    logic                          scorer_go, scorer_green_last, scorer_done;

    // The row being typed or scored is always the one at guess_count.
    assign row_idx = RIW'(guess_count_q);

    for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_row
        assign cur_guess[gi*LETTER_W +: LETTER_W] = letters_q[row_idx][gi];
        assign green_vec[gi] = (score_cols[2*gi +: 2] == COL_GREEN);
    end
    assign all_green = &green_vec;

    wordle_scorer #(
        .WORD_LEN (WORD_LEN),
        .LETTER_W (LETTER_W)
    ) u_scorer (
        .board_clk  (board_clk),
        .reset      (reset),
        .go         (scorer_go),
        .abort      (start),
        .guess      (cur_guess),
        .secret     (secret_q),
        .colours    (score_cols),
        .green_last (scorer_green_last),
        .done       (scorer_done)
    );

    // Game FSM next state: start overrides everything, entry actions are
    // one per cycle with submit > backspace > letter.
    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        guess_count_d = guess_count_q;
        secret_d      = secret_q;
        letters_d     = letters_q;
        colours_d     = colours_q;
        win_d         = win_q;
        lose_d        = lose_q;
        scorer_go     = 1'b0;
        if (start) begin
            state_d       = ST_ENTRY;
            cursor_d      = '0;
            guess_count_d = '0;
            secret_d      = secret_word;
            win_d         = 1'b0;
            lose_d        = 1'b0;
            for (int r = 0; r < MAX_GUESSES; r++) begin
                for (int c = 0; c < WORD_LEN; c++) begin
                    letters_d[r][c] = '0;
                    colours_d[r][c] = COL_EMPTY;
                end
            end
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (submit) begin
                        if (int'(cursor_q) == WORD_LEN) begin
                            state_d   = ST_GREEN;
                            scorer_go = 1'b1;
                        end
                    end else if (backspace) begin
                        if (cursor_q != '0) begin
                            cursor_d = cursor_q - 1'b1;
                            letters_d[row_idx][CIW'(cursor_q - 1'b1)] = '0;
                        end
                    end else if (letter_valid) begin
                        if ((int'(cursor_q) < WORD_LEN) && letter_is_valid(int'(letter))) begin
                            letters_d[row_idx][CIW'(cursor_q)] = letter;
                            cursor_d = cursor_q + 1'b1;
                        end
                    end
                end
                ST_GREEN: begin
                    if (scorer_green_last) state_d = ST_YELLOW;
                end
                ST_YELLOW: begin
                    if (scorer_done) state_d = ST_UPDATE;
                end
                ST_UPDATE: begin
                    for (int c = 0; c < WORD_LEN; c++) begin
                        colours_d[row_idx][c] = score_cols[2*c +: 2];
                    end
                    guess_count_d = guess_count_q + 1'b1;
                    if (all_green) begin
                        win_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (int'(guess_count_q) + 1 == MAX_GUESSES) begin
                        lose_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cursor_d = '0;
                        state_d  = ST_ENTRY;
                    end
                end
                default: ;
            endcase
        end
        busy_d       = (state_d == ST_GREEN) || (state_d == ST_YELLOW) || (state_d == ST_UPDATE);
        score_done_d = (state_d == ST_UPDATE);
    end

    // Game state, board storage and registered status outputs.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cursor_q      <= '0;
            guess_count_q <= '0;
            secret_q      <= '0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            busy_q        <= 1'b0;
            score_done_q  <= 1'b0;
            for (int r = 0; r < MAX_GUESSES; r++) begin
                for (int c = 0; c < WORD_LEN; c++) begin
                    letters_q[r][c] <= '0;
                    colours_q[r][c] <= COL_EMPTY;
                end
            end
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            guess_count_q <= guess_count_d;
            secret_q      <= secret_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            busy_q        <= busy_d;
            score_done_q  <= score_done_d;
            letters_q     <= letters_d;
            colours_q     <= colours_d;
        end
    end

    // Renderer read port; out-of-range coordinates read as an empty tile.
    always_comb begin
        rd_letter = '0;
        rd_colour = COL_EMPTY;
        if ((int'(rd_row) < MAX_GUESSES) && (int'(rd_col) < WORD_LEN)) begin
            rd_letter = letters_q[rd_row][rd_col];
            rd_colour = colours_q[rd_row][rd_col];
        end
    end

    assign busy        = busy_q;
    assign score_done  = score_done_q;
    assign guess_count = guess_count_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule

// File: tb/tb_wordle_game_core.sv
// Randomised scoreboard bench for wordle_game_core. The stimulus process
// keeps a word-level model of the game and pushes the expected result of
// every accepted guess; a monitor pops and checks it on score_done.
module tb_wordle_game_core;
    localparam int WL  = 5;
    localparam int MG  = 6;
    localparam int LW  = 5;
    localparam int LAT = WL + WL * WL + 1;

    logic            board_clk = 1'b0;
    logic            reset, start, letter_valid, backspace, submit;
    logic [WL*LW-1:0] secret_word;
    logic [LW-1:0]   letter;
    logic [2:0]      rd_row, rd_col, main_row, main_col, mon_row, mon_col;
    logic            mon_active;
    logic [LW-1:0]   rd_letter;
    logic [1:0]      rd_colour;
    logic            busy, score_done, win, lose;
    logic [2:0]      guess_count;

    assign rd_row = mon_active ? mon_row : main_row;
    assign rd_col = mon_active ? mon_col : main_col;

    wordle_game_core #(.WORD_LEN(WL), .MAX_GUESSES(MG), .LETTER_W(LW)) dut (
        .board_clk    (board_clk),
        .reset        (reset),
        .start        (start),
        .secret_word  (secret_word),
        .letter_valid (letter_valid),
        .letter       (letter),
        .backspace    (backspace),
        .submit       (submit),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_letter    (rd_letter),
        .rd_colour    (rd_colour),
        .busy         (busy),
        .score_done   (score_done),
        .guess_count  (guess_count),
        .win          (win),
        .lose         (lose)
    );

    always #10 board_clk = ~board_clk;

    int cyc = 0;
    always @(posedge board_clk) cyc <= cyc + 1;

    typedef struct {
        int               row;
        logic [2*WL-1:0]  cols;
        logic [WL*LW-1:0] lets;
        int               gc;
        int               win;
        int               lose;
        int               sub_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   exp_done = 0;
    int   done_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    // Word-level game model (mode: 0 idle, 1 entry, 2 done).
    int m_let [MG][WL];
    int m_col [MG][WL];
    int m_cursor, m_gc, m_win, m_lose, m_mode;
    int m_secret [WL];
    int cur_guess [WL];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Standard Wordle colouring by letter counts: greens first, then yellows
    // left to right while unmatched copies of that letter remain.
    function automatic logic [2*WL-1:0] ref_score();
        int cnt [26];
        int col [WL];
        logic [2*WL-1:0] r;
        for (int k = 0; k < 26; k++) cnt[k] = 0;
        for (int i = 0; i < WL; i++) begin
            if (cur_guess[i] == m_secret[i]) col[i] = 3;
            else begin
                col[i] = 0;
                cnt[m_secret[i]]++;
            end
        end
        for (int i = 0; i < WL; i++) begin
            if (col[i] != 3) begin
                if (cnt[cur_guess[i]] > 0) begin
                    col[i] = 2;
                    cnt[cur_guess[i]]--;
                end else begin
                    col[i] = 1;
                end
            end
        end
        r = '0;
        for (int i = 0; i < WL; i++) r[2*i +: 2] = 2'(col[i]);
        return r;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < MG; r++)
            for (int c = 0; c < WL; c++) begin
                m_let[r][c] = 0;
                m_col[r][c] = 0;
            end
        m_cursor = 0; m_gc = 0; m_win = 0; m_lose = 0;
    endtask

    task automatic do_start();
        for (int i = 0; i < WL; i++) secret_word[i*LW +: LW] = LW'(m_secret[i]);
        start = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        model_clear();
        m_mode = 1;
    endtask

    task automatic type_letter(input int code);
        letter = LW'(code);
        letter_valid = 1'b1;
        @(negedge board_clk);
        letter_valid = 1'b0;
        if (m_mode == 1 && m_cursor < WL && code <= 25) begin
            m_let[m_gc][m_cursor] = code;
            m_cursor++;
        end
    endtask

    task automatic do_backspace();
        backspace = 1'b1;
        @(negedge board_clk);
        backspace = 1'b0;
        if (m_mode == 1 && m_cursor > 0) begin
            m_cursor--;
            m_let[m_gc][m_cursor] = 0;
        end
    endtask

    task automatic wait_scored();
        int n;
        n = 0;
        while (done_cnt != exp_done && n < 4 * LAT) begin
            @(negedge board_clk);
            n++;
        end
        chk("score_complete", done_cnt, exp_done);
    endtask

    task automatic do_submit();
        exp_t e;
        bit   acc;
        acc = (m_mode == 1 && m_cursor == WL);
        if (acc) begin
            for (int i = 0; i < WL; i++) begin
                cur_guess[i] = m_let[m_gc][i];
                e.lets[i*LW +: LW] = LW'(cur_guess[i]);
            end
            e.row     = m_gc;
            e.cols    = ref_score();
            e.gc      = m_gc + 1;
            e.win     = (e.cols == '1) ? 1 : 0;
            e.lose    = (e.win == 0 && m_gc + 1 == MG) ? 1 : 0;
            e.sub_cyc = cyc;
            exp_q.push_back(e);
            exp_done++;
        end
        submit = 1'b1;
        @(negedge board_clk);
        submit = 1'b0;
        chk("busy_after_submit", busy, acc ? 1 : 0);
        if (acc) begin
            wait_scored();
            for (int i = 0; i < WL; i++) m_col[e.row][i] = int'(e.cols[2*i +: 2]);
            m_gc++;
            if (e.win == 1)       begin m_win = 1;  m_mode = 2; end
            else if (m_gc == MG)  begin m_lose = 1; m_mode = 2; end
            else                  m_cursor = 0;
        end
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_guess_count"}, guess_count, m_gc);
        chk({tag, "_win"}, win, m_win);
        chk({tag, "_lose"}, lose, m_lose);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_score_done"}, score_done, 0);
    endtask

    // Sweeps the whole read address space, including out-of-range tiles.
    task automatic check_board(input string tag);
        int el, ec;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                main_row = 3'(r);
                main_col = 3'(c);
                #1;
                el = 0; ec = 0;
                if (r < MG && c < WL) begin
                    el = m_let[r][c];
                    ec = m_col[r][c];
                end
                chk({tag, "_tile_letter"}, rd_letter, el);
                chk({tag, "_tile_colour"}, rd_colour, ec);
            end
        end
        @(negedge board_clk);
    endtask

    task automatic set_secret5(input int a, input int b, input int c, input int d, input int e);
        m_secret[0] = a; m_secret[1] = b; m_secret[2] = c; m_secret[3] = d; m_secret[4] = e;
    endtask

    task automatic type5(input int a, input int b, input int c, input int d, input int e);
        type_letter(a); type_letter(b); type_letter(c); type_letter(d); type_letter(e);
    endtask

    task automatic random_secret();
        for (int i = 0; i < WL; i++) m_secret[i] = int'($urandom_range(0, 5));
    endtask

    // One guess with occasional typo+backspace, invalid codes and overflow letters.
    task automatic play_random_guess(input bit allow_win);
        int  g [WL];
        bit  same;
        for (int i = 0; i < WL; i++) g[i] = int'($urandom_range(0, 5));
        if (allow_win && $urandom_range(0, 3) == 0) g = m_secret;
        if (!allow_win) begin
            same = 1'b1;
            for (int i = 0; i < WL; i++) if (g[i] != m_secret[i]) same = 1'b0;
            if (same) g[0] = (m_secret[0] + 1) % 26;
        end
        for (int i = 0; i < WL; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                type_letter(int'($urandom_range(0, 25)));
                do_backspace();
            end
            if ($urandom_range(0, 6) == 0) type_letter(int'($urandom_range(26, 31)));
            type_letter(g[i]);
        end
        if ($urandom_range(0, 3) == 0) type_letter(int'($urandom_range(0, 25)));
        do_submit();
    endtask

    // Scoreboard monitor: checks latency on score_done, then the committed
    // row and status one cycle later.
    initial begin
        exp_t e;
        mon_active = 1'b0;
        mon_row    = '0;
        mon_col    = '0;
        forever begin
            @(negedge board_clk);
            if (score_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("score_done_unexpected", score_done, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("score_latency", cyc - e.sub_cyc, LAT);
                    @(negedge board_clk);
                    mon_active = 1'b1;
                    mon_row    = 3'(e.row);
                    for (int c = 0; c < WL; c++) begin
                        mon_col = 3'(c);
                        #1;
                        chk("row_colour", rd_colour, int'(e.cols[2*c +: 2]));
                        chk("row_letter", rd_letter, int'(e.lets[c*LW +: LW]));
                    end
                    mon_active = 1'b0;
                    chk("post_guess_count", guess_count, e.gc);
                    chk("post_win", win, e.win);
                    chk("post_lose", lose, e.lose);
                    chk("post_busy", busy, 0);
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; letter_valid = 1'b0; backspace = 1'b0; submit = 1'b0;
        secret_word = '0; letter = '0; main_row = '0; main_col = '0;
        m_mode = 0;
        model_clear();
        for (int i = 0; i < WL; i++) m_secret[i] = 0;
        repeat (3) @(negedge board_clk);
        check_flags("reset");
        check_board("reset");
        reset = 1'b0;
        @(negedge board_clk);

        // Idle: typing has no effect.
        type_letter(3);
        do_submit();
        check_board("idle");

        // CRANE solved first try.
        set_secret5(2, 17, 0, 13, 4);
        do_start();
        type5(2, 17, 0, 13, 4);
        do_submit();
        check_flags("crane");
        // Done: further input is ignored.
        type_letter(7);
        do_backspace();
        do_submit();
        check_board("crane_done");

        // Restart with ABBEY; board must be clear and the new secret used.
        set_secret5(0, 1, 1, 4, 24);
        do_start();
        check_flags("restart");
        check_board("restart");
        type5(1, 14, 1, 1, 24);
        do_submit();
        check_flags("bobby");

        // Entry edge cases on row 1.
        type_letter(0); type_letter(1); type_letter(2);
        do_submit();
        repeat (4) do_backspace();
        check_board("backspaced");
        type_letter(27);
        type5(3, 4, 5, 6, 7);
        type_letter(8);
        check_board("overflow");
        do_submit();
        while (m_mode == 1) play_random_guess(1'b1);
        check_flags("abbey_end");

        // Random games with small alphabets for frequent duplicates.
        for (int gm = 0; gm < 4; gm++) begin
            random_secret();
            do_start();
            while (m_mode == 1) play_random_guess(1'b1);
            check_flags("random_game");
            check_board("random_game");
        end

        // Six wrong guesses -> lose, board frozen afterwards.
        random_secret();
        do_start();
        for (int k = 0; k < MG; k++) play_random_guess(1'b0);
        check_flags("lost");
        type5(1, 2, 3, 4, 5);
        do_submit();
        check_board("lost_frozen");

        // Reset ten cycles into the yellow pass.
        random_secret();
        do_start();
        type5(0, 1, 2, 3, 4);
        submit = 1'b1;
        @(negedge board_clk);
        submit = 1'b0;
        repeat (WL + 10) @(negedge board_clk);
        chk("busy_mid_yellow", busy, 1);
        reset = 1'b1;
        #1;
        m_mode = 0;
        model_clear();
        exp_q.delete();
        check_flags("abort");
        check_board("abort");
        reset = 1'b0;
        @(negedge board_clk);
        type_letter(9);
        check_board("abort_idle");

        // Fresh game after the abort still scores correctly.
        set_secret5(2, 17, 0, 13, 4);
        do_start();
        type5(4, 13, 0, 17, 2);
        do_submit();
        type5(2, 17, 0, 13, 4);
        do_submit();
        check_flags("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
